timer_int_ctrl_mc: RTL and testbench

- Multi-channel successor to the single-channel timer interrupt controller.
- Collects compare events from NUM_CH timer channels into sticky per-channel status bits, with these per-channel features:
  - level or rising-edge qualification;
  - event coalescing threshold;
  - overrun flagging.
- Drives one combined interrupt line and a registered lowest-index pending-channel ID with an acknowledge handshake.
- Sits between the timer counter/compare channels and the register interface / CPU interrupt input.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_int_ctrl_mc_if.sv | 25 ++
 rtl/timer_int_ch.sv | 56 +++++
 rtl/timer_int_ctrl_mc.sv | 62 ++++++
 tb/tb_timer_int_ctrl_mc.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer interrupt controller.
package timer_pkg;

    localparam int TIM_NUM_CH = 4;
    localparam int TIM_CNT_W  = 8;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Index of the lowest set bit, 0 when none is set.
    function automatic int ffs_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_int_ctrl_mc_if.sv
// Interrupt presentation handshake between controller and CPU.
interface timer_int_ctrl_mc_if #(
    parameter int ID_W = 2
);

    logic            tim_int;
    logic [ID_W-1:0] int_id;
    logic            int_id_vld;
    logic            int_ack;

    modport master (
        output tim_int,
        output int_id,
        output int_id_vld,
        input  int_ack
    );

    modport slave (
        input  tim_int,
        input  int_id,
        input  int_id_vld,
        output int_ack
    );

endinterface

// File: rtl/timer_int_ch.sv
// One timer channel: edge/level qualify, event coalescing, sticky status.
module timer_int_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt,
    input  logic             edge_mode,
    input  logic [CNT_W-1:0] thr_m1,
    input  logic             int_set,
    input  logic             int_clr,
    input  logic             ack_clr,
    output logic             int_st,
    output logic             ovr_st
);

    logic             evt_d;
    logic [CNT_W-1:0] cnt;
    logic             q;
    logic             fire;
    logic             set;
    logic             clr;

    assign q    = edge_mode ? (evt & ~evt_d) : evt;
    assign fire = q & (cnt >= thr_m1);
    assign set  = fire | int_set;
    assign clr  = int_clr | ack_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_d  <= 1'b0;
            cnt    <= '0;
            int_st <= 1'b0;
            ovr_st <= 1'b0;
        end else begin
            evt_d <= evt;
            if (fire) begin
                cnt <= '0;
            end else if (q) begin
                cnt <= cnt + 1'b1;
            end
            // A new set always wins so no event is lost to a clear.
            if (set) begin
                int_st <= 1'b1;
            end else if (clr) begin
                int_st <= 1'b0;
            end
            if (set & int_st & ~ack_clr) begin
                ovr_st <= 1'b1;
            end else if (int_clr) begin
                ovr_st <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_int_ctrl_mc.sv
// Multi-channel timer interrupt controller with registered pending-ID.
module timer_int_ctrl_mc
    import timer_pkg::*;
#(
    parameter int NUM_CH = TIM_NUM_CH,
    parameter int CNT_W  = TIM_CNT_W,
    parameter int ID_W   = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] evt,
    input  logic [NUM_CH-1:0] edge_mode,
    input  logic [NUM_CH-1:0] int_en,
    input  logic [NUM_CH-1:0] int_clr,
    input  logic [NUM_CH-1:0] int_set,
    input  logic [CNT_W-1:0]  thr,
    output logic [NUM_CH-1:0] int_st,
    output logic [NUM_CH-1:0] ovr_st,
    timer_int_ctrl_mc_if.master irq
);

    logic [CNT_W-1:0]  thr_m1;
    logic [NUM_CH-1:0] masked;
    logic [NUM_CH-1:0] ack_clr;

    // A threshold of zero behaves like one.
    assign thr_m1 = (thr == '0) ? '0 : thr - 1'b1;
    assign masked = int_st & int_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ack_clr[i] = irq.int_ack & irq.int_id_vld
                          & (irq.int_id == ID_W'(i));

        timer_int_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .evt       (evt[i]),
            .edge_mode (edge_mode[i]),
            .thr_m1    (thr_m1),
            .int_set   (int_set[i]),
            .int_clr   (int_clr[i]),
            .ack_clr   (ack_clr[i]),
            .int_st    (int_st[i]),
            .ovr_st    (ovr_st[i])
        );
    end

    assign irq.tim_int = |masked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq.int_id_vld <= 1'b0;
            irq.int_id     <= '0;
        end else begin
            irq.int_id_vld <= |masked;
            irq.int_id     <= ID_W'(ffs_idx(32'(masked)));
        end
    end

endmodule

// File: tb/tb_timer_int_ctrl_mc.sv
// Scoreboard bench for timer_int_ctrl_mc against a behavioural model.
module tb_timer_int_ctrl_mc;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  evt = '0;
    logic [N-1:0]  edge_mode = '0;
    logic [N-1:0]  int_en = '0;
    logic [N-1:0]  int_clr = '0;
    logic [N-1:0]  int_set = '0;
    logic [CW-1:0] thr = 8'd1;
    logic [N-1:0]  int_st;
    logic [N-1:0]  ovr_st;

    timer_int_ctrl_mc_if #(.ID_W(IW)) irq ();

    timer_int_ctrl_mc #(
        .NUM_CH (N),
        .CNT_W  (CW),
        .ID_W   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .evt       (evt),
        .edge_mode (edge_mode),
        .int_en    (int_en),
        .int_clr   (int_clr),
        .int_set   (int_set),
        .thr       (thr),
        .int_st    (int_st),
        .ovr_st    (ovr_st),
        .irq       (irq.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  st;
        logic [N-1:0]  ovr;
        logic          ti;
        logic [IW-1:0] id;
        logic          vld;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    logic [N-1:0] m_st;
    logic [N-1:0] m_ovr;
    logic [N-1:0] m_prev;
    int           m_cnt[N];
    int           m_id;
    bit           m_vld;

    function automatic void model_reset();
        m_st   = '0;
        m_ovr  = '0;
        m_prev = '0;
        m_id   = 0;
        m_vld  = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    function automatic void push_state();
        exp_t e;
        e.st  = m_st;
        e.ovr = m_ovr;
        e.ti  = |(m_st & int_en);
        e.id  = IW'(m_id);
        e.vld = m_vld;
        sb.push_back(e);
    endfunction

    // Apply the current inputs for one clock and predict the result.
    task automatic step();
        int           te;
        int           lo;
        bit           q;
        bit           fire;
        bit           ackh;
        bit           sw;
        logic [N-1:0] nst;
        logic [N-1:0] novr;
        te   = (thr == 0) ? 1 : int'(thr);
        nst  = m_st;
        novr = m_ovr;
        for (int i = 0; i < N; i++) begin
            q    = edge_mode[i] ? (evt[i] && !m_prev[i]) : evt[i];
            fire = q && (m_cnt[i] + 1 >= te);
            if (fire) m_cnt[i] = 0;
            else if (q) m_cnt[i] = m_cnt[i] + 1;
            ackh = irq.int_ack && m_vld && (m_id == i);
            sw   = fire || int_set[i];
            if (sw) nst[i] = 1'b1;
            else if (int_clr[i] || ackh) nst[i] = 1'b0;
            if (sw && m_st[i] && !ackh) novr[i] = 1'b1;
            else if (int_clr[i]) novr[i] = 1'b0;
        end
        lo = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_st[i] && int_en[i]) lo = i;
        end
        m_vld  = (lo >= 0);
        m_id   = (lo >= 0) ? lo : 0;
        m_st   = nst;
        m_ovr  = novr;
        m_prev = evt;
        push_state();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        push_state();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        evt         = '0;
        int_clr     = '0;
        int_set     = '0;
        irq.int_ack = 1'b0;
    endtask

    task automatic pulse0(input int n);
        repeat (n) begin
            evt = 4'b0001;
            step();
            evt = '0;
            step();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                exp_t a;
                e = sb.pop_front();
                a = {int_st, ovr_st, irq.tim_int, irq.int_id, irq.int_id_vld};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec %0d: got st=%b ovr=%b int=%b id=%0d vld=%b, want st=%b ovr=%b int=%b id=%0d vld=%b",
                             vectors, a.st, a.ovr, a.ti, a.id, a.vld,
                             e.st, e.ovr, e.ti, e.id, e.vld);
                end
            end
        end
    end

    initial begin
        bit last_ack;
        irq.int_ack = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        step();

        // Level events on ch0, thr=1: status then overrun
        int_en = 4'b0001;
        evt = 4'b0001;
        steps(3);
        idle();
        steps(2);
        int_clr = '1;
        step();
        idle();
        step();

        // Edge mode on ch1, thr=3: held level then pulses
        edge_mode = 4'b0010;
        thr = 8'd3;
        evt = 4'b0010;
        steps(10);
        idle();
        step();
        repeat (3) begin
            evt = 4'b0010;
            step();
            evt = '0;
            steps(2);
        end
        int_clr = '1;
        step();
        idle();

        // Set and clear collide on ch2
        edge_mode = '0;
        thr = 8'd1;
        evt = 4'b0100;
        step();
        evt = '0;
        step();
        evt = 4'b0100;
        int_clr = 4'b0100;
        step();
        idle();
        step();
        int_clr = '1;
        step();
        idle();

        // Priority ID and ack walk
        int_en = '1;
        int_set = 4'b1010;
        step();
        idle();
        step();
        irq.int_ack = 1'b1;
        step();
        irq.int_ack = 1'b0;
        steps(2);
        irq.int_ack = 1'b1;
        step();
        irq.int_ack = 1'b0;
        steps(2);
        int_clr = '1;
        step();
        idle();

        // Masked channel, then late enable
        int_en = '0;
        evt = 4'b1000;
        step();
        evt = '0;
        steps(2);
        int_en = 4'b1000;
        steps(2);
        int_clr = '1;
        step();
        idle();

        // thr=0 acts as 1, then reset mid-count with thr=5
        int_en = '1;
        thr = 8'd0;
        pulse0(1);
        int_clr = '1;
        step();
        idle();
        thr = 8'd5;
        pulse0(2);
        do_reset();
        step();
        pulse0(4);
        steps(2);
        pulse0(1);
        steps(2);
        int_clr = '1;
        step();
        idle();

        // Randomized traffic
        last_ack = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle();
                do_reset();
            end
            evt = 4'($urandom);
            if ($urandom_range(0, 15) == 0) edge_mode = 4'($urandom);
            if ($urandom_range(0, 7) == 0) int_en = 4'($urandom);
            int_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            int_set = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 19) == 0) thr = 8'($urandom_range(0, 4));
            irq.int_ack = !last_ack && ($urandom_range(0, 2) == 0);
            last_ack = irq.int_ack;
            step();
        end
        idle();
        steps(2);
        repeat (2) @(negedge clk);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
